// File: rtl/round_key_store.sv
// Purpose : round-key register file between the key-schedule generator and the
//           cipher round datapath; replays stored keys ascending (encrypt) or
//           descending (decrypt) over a valid/ready stream.
// Ports   : i_clk/i_reset (async active-high); generator side i_key_start,
//           i_rounds_total, i_wr_en/i_wr_addr/i_wr_key, i_wr_done; replay side
//           i_rd_start, i_rd_decrypt, i_rd_ready -> o_rd_valid/o_rd_key/o_rd_last;
//           status o_keys_ready, o_key_err (sticky until next load), o_busy.
//           First replayed key appears two edges after i_rd_start, then one key
//           per cycle; outputs hold while o_rd_valid && !i_rd_ready.
module round_key_store #(
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_key_start,
    input  logic [ADDR_W-1:0] i_rounds_total,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [KEY_W-1:0]  i_wr_key,
    input  logic              i_wr_done,
    input  logic              i_rd_start,
    input  logic              i_rd_decrypt,
    input  logic              i_rd_ready,
    output logic              o_rd_valid,
    output logic [KEY_W-1:0]  o_rd_key,
    output logic              o_rd_last,
    output logic              o_keys_ready,
    output logic              o_key_err,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_READY  = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    // One extra bit so nr+1 (up to 15) and overshoot are representable.
    localparam int CNT_W = ADDR_W + 1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_nr;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic                r_pend_err;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_dir;       // 1 = descending replay
    logic                r_more;      // keys still to be loaded into the output register
    logic                r_rd_valid;
    logic [KEY_W-1:0]    r_rd_key;
    logic                r_rd_last;
    logic                r_keys_ready;
    logic                r_key_err;
    logic                r_busy;

    logic [KEY_W-1:0]    r_mem [DEPTH];

    logic                w_nr_valid;
    logic                w_wr_in_range;
    logic                w_wr_store;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_pend_next;
    logic [CNT_W-1:0]    w_cnt_goal;
    logic [ADDR_W-1:0]   w_ptr_end;
    logic                w_at_end;
    logic                w_load;
    logic                w_xfer_last;
    logic [KEY_W-1:0]    w_mem_rd;

    assign w_nr_valid    = (i_rounds_total == ADDR_W'(10)) ||
                           (i_rounds_total == ADDR_W'(12)) ||
                           (i_rounds_total == ADDR_W'(14));
    assign w_wr_in_range = (i_wr_addr <= r_nr);
    // A key_start in the same cycle restarts the load, so that cycle's write is dropped.
    assign w_wr_store    = (r_state == S_LOAD) && !i_key_start && i_wr_en && w_wr_in_range;
    // Saturating so a flood of duplicate writes can never wrap back onto nr+1.
    assign w_cnt_next    = (w_wr_store && (r_wr_cnt != '1)) ? r_wr_cnt + CNT_W'(1) : r_wr_cnt;
    assign w_pend_next   = r_pend_err | (i_wr_en && !w_wr_in_range);
    assign w_cnt_goal    = {1'b0, r_nr} + CNT_W'(1);
    assign w_ptr_end     = r_dir ? ADDR_W'(0) : r_nr;
    assign w_at_end      = (r_ptr == w_ptr_end);
    assign w_load        = (!r_rd_valid || i_rd_ready) && r_more;
    assign w_xfer_last   = r_rd_valid && i_rd_ready && r_rd_last;
    assign w_mem_rd      = r_mem[r_ptr];

    // Storage is deliberately not reset; the FSM keeps it unreadable until a good load.
    always_ff @(posedge i_clk) begin
        if (w_wr_store) begin
            r_mem[i_wr_addr] <= i_wr_key;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_nr         <= '0;
            r_wr_cnt     <= '0;
            r_pend_err   <= 1'b0;
            r_ptr        <= '0;
            r_dir        <= 1'b0;
            r_more       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_key     <= '0;
            r_rd_last    <= 1'b0;
            r_keys_ready <= 1'b0;
            r_key_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else if (i_key_start) begin
            // Restart from any state, aborting a replay in flight.
            r_nr         <= i_rounds_total;
            r_wr_cnt     <= '0;
            r_pend_err   <= 1'b0;
            r_more       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_keys_ready <= 1'b0;
            if (w_nr_valid) begin
                r_state   <= S_LOAD;
                r_key_err <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                r_state   <= S_IDLE;
                r_key_err <= 1'b1;
                r_busy    <= 1'b0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_wr_cnt   <= w_cnt_next;
                    r_pend_err <= w_pend_next;
                    if (i_wr_done) begin
                        r_busy <= 1'b0;
                        if ((w_cnt_next == w_cnt_goal) && !w_pend_next) begin
                            r_state      <= S_READY;
                            r_keys_ready <= 1'b1;
                        end else begin
                            r_state   <= S_IDLE;
                            r_key_err <= 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (i_rd_start) begin
                        r_dir        <= i_rd_decrypt;
                        r_ptr        <= i_rd_decrypt ? r_nr : ADDR_W'(0);
                        r_more       <= 1'b1;
                        r_state      <= S_STREAM;
                        r_keys_ready <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_xfer_last) begin
                        r_state      <= S_READY;
                        r_rd_valid   <= 1'b0;
                        r_rd_last    <= 1'b0;
                        r_keys_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end else if (w_load) begin
                        r_rd_key   <= w_mem_rd;
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= w_at_end;
                        // Pointer stops at the end address instead of stepping past it.
                        if (w_at_end) begin
                            r_more <= 1'b0;
                        end else if (r_dir) begin
                            r_ptr <= r_ptr - ADDR_W'(1);
                        end else begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rd_valid   = r_rd_valid;
    assign o_rd_key     = r_rd_key;
    assign o_rd_last    = r_rd_last;
    assign o_keys_ready = r_keys_ready;
    assign o_key_err    = r_key_err;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_round_key_store.sv
// Purpose : directed self-checking bench for round_key_store.
// Latency : inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: i_rd_ready held high or toggled per scenario.
module tb_round_key_store;

    localparam int KEY_W  = 128;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              key_start;
    logic [ADDR_W-1:0] rounds_total;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [KEY_W-1:0]  wr_key;
    logic              wr_done;
    logic              rd_start;
    logic              rd_decrypt;
    logic              rd_ready;
    logic              rd_valid;
    logic [KEY_W-1:0]  rd_key;
    logic              rd_last;
    logic              keys_ready;
    logic              key_err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    round_key_store #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .DEPTH(15)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_key_start    (key_start),
        .i_rounds_total (rounds_total),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_key       (wr_key),
        .i_wr_done      (wr_done),
        .i_rd_start     (rd_start),
        .i_rd_decrypt   (rd_decrypt),
        .i_rd_ready     (rd_ready),
        .o_rd_valid     (rd_valid),
        .o_rd_key       (rd_key),
        .o_rd_last      (rd_last),
        .o_keys_ready   (keys_ready),
        .o_key_err      (key_err),
        .o_busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Distinct, recognisable key per (set, address).
    function automatic logic [KEY_W-1:0] kv(input int s, input int a);
        return {32'(s), 32'hC0DE_0000 | 32'(a), 32'(a * 3 + s), 32'hFEED_0000 + 32'(a)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, rd_valid, 0);
        check_eq({tag, "_last"},  rd_last, 0);
        check_eq({tag, "_key"},   rd_key, 0);
        check_eq({tag, "_kr"},    keys_ready, 0);
        check_eq({tag, "_err"},   key_err, 0);
        check_eq({tag, "_busy"},  busy, 0);
    endtask

    // key_start in the current cycle, then one write per address 0..nr with wr_done on the last.
    task automatic load_keys(input int nr, input int set);
        key_start    = 1'b1;
        rounds_total = ADDR_W'(nr);
        tick;
        key_start = 1'b0;
        check_eq("ld_busy", busy, 1);
        check_eq("ld_kr", keys_ready, 0);
        check_eq("ld_valid", rd_valid, 0);
        for (int a = 0; a <= nr; a++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(a);
            wr_key  = kv(set, a);
            wr_done = (a == nr);
            tick;
        end
        wr_en   = 1'b0;
        wr_done = 1'b0;
        check_eq("ld_done_kr", keys_ready, 1);
        check_eq("ld_done_err", key_err, 0);
        check_eq("ld_done_busy", busy, 0);
    endtask

    task automatic replay_enc(input int nr, input int set);
        rd_ready   = 1'b1;
        rd_decrypt = 1'b0;
        rd_start   = 1'b1;
        tick;
        rd_start = 1'b0;
        check_eq("enc_lat", rd_valid, 0);
        for (int i = 0; i <= nr; i++) begin
            tick;
            check_eq("enc_valid", rd_valid, 1);
            check_eq("enc_key", rd_key, kv(set, i));
            check_eq("enc_last", rd_last, (i == nr) ? 1 : 0);
            if (i == 0) check_eq("enc_busy", busy, 1);
        end
        tick;
        check_eq("enc_end_valid", rd_valid, 0);
        check_eq("enc_end_kr", keys_ready, 1);
        check_eq("enc_end_busy", busy, 0);
    endtask

    initial begin
        logic [KEY_W-1:0] prev_key;
        logic             stalled;
        int               exp_idx;
        logic             done;
        logic             seen;

        reset = 1'b1; key_start = 0; rounds_total = 0; wr_en = 0; wr_addr = 0;
        wr_key = 0; wr_done = 0; rd_start = 0; rd_decrypt = 0; rd_ready = 0;
        #2;
        check_idle_outputs("rst");
        tick;
        reset = 1'b0;

        // AES-128 load, stray write in READY must not land, then ascending replay twice.
        load_keys(10, 1);
        wr_en = 1'b1; wr_addr = 4'd3; wr_key = '1;
        tick;
        wr_en = 1'b0;
        replay_enc(10, 1);
        replay_enc(10, 1);

        // AES-256 descending replay with rd_ready toggling every cycle.
        load_keys(14, 2);
        rd_ready = 1'b0; rd_decrypt = 1'b1; rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        exp_idx = 14; done = 1'b0; stalled = 1'b0; prev_key = '0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            tick;
            rd_ready = (cyc % 2) == 1;
            if (rd_valid) begin
                check_eq("dec_key", rd_key, kv(2, exp_idx));
                check_eq("dec_last", rd_last, (exp_idx == 0) ? 1 : 0);
                if (stalled) check_eq("dec_hold", rd_key, prev_key);
                if (rd_ready) begin
                    stalled = 1'b0;
                    if (exp_idx == 0) done = 1'b1;
                    else exp_idx--;
                end else begin
                    stalled  = 1'b1;
                    prev_key = rd_key;
                end
            end
        end
        check_eq("dec_done", done, 1);
        tick;
        check_eq("dec_end_valid", rd_valid, 0);
        check_eq("dec_end_kr", keys_ready, 1);

        // Incomplete AES-192 schedule: addresses 0..11 only.
        key_start = 1'b1; rounds_total = 4'd12;
        tick;
        key_start = 1'b0;
        for (int a = 0; a <= 11; a++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_key = kv(3, a);
            tick;
        end
        wr_en = 1'b0; wr_done = 1'b1;
        tick;
        wr_done = 1'b0;
        check_eq("inc_err", key_err, 1);
        check_eq("inc_kr", keys_ready, 0);
        check_eq("inc_busy", busy, 0);
        rd_ready = 1'b1; rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (rd_valid) seen = 1'b1;
            tick;
        end
        check_eq("inc_no_valid", seen, 0);

        // Unsupported round count.
        key_start = 1'b1; rounds_total = 4'd9;
        tick;
        key_start = 1'b0;
        check_eq("nr9_err", key_err, 1);
        check_eq("nr9_busy", busy, 0);
        check_eq("nr9_kr", keys_ready, 0);

        // Out-of-range address poisons an otherwise full load.
        key_start = 1'b1; rounds_total = 4'd10;
        tick;
        key_start = 1'b0;
        check_eq("oor_err_clr", key_err, 0);
        for (int a = 0; a <= 10; a++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_key = kv(4, a);
            tick;
        end
        wr_addr = 4'd12;
        tick;
        wr_en = 1'b0; wr_done = 1'b1;
        tick;
        wr_done = 1'b0;
        check_eq("oor_err", key_err, 1);
        check_eq("oor_kr", keys_ready, 0);

        // Abort on the 4th key, reload new values, replay them.
        load_keys(10, 5);
        rd_ready = 1'b1; rd_decrypt = 1'b0; rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_eq("abt_key", rd_key, kv(5, i));
        end
        load_keys(10, 6);
        replay_enc(10, 6);

        // Asynchronous reset between edges during a replay.
        rd_ready = 1'b1; rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        tick;
        tick;
        check_eq("ar_pre_valid", rd_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("ar");
        tick;
        reset = 1'b0;
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (rd_valid) seen = 1'b1;
            tick;
        end
        check_eq("ar_no_valid", seen, 0);
        check_eq("ar_kr", keys_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
